// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enabled word RAM plus an MMIO window holding a
// console byte FIFO (drained on a valid/ready stream) and a 64-bit cycle counter.
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_en,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_d,
   input  logic [3:0]  dmem_we,
   output logic [31:0] dmem_q,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready
);

   localparam int unsigned RAM_WORDS = 2 ** ADDR_WIDTH;
   localparam int unsigned IW        = $clog2(FIFO_DEPTH);
   localparam int unsigned PW        = IW + 1;

   localparam logic [15:0] OFF_CONSOLE  = 16'h0000;
   localparam logic [15:0] OFF_STATUS   = 16'h0004;
   localparam logic [15:0] OFF_CYCLE_LO = 16'h0008;
   localparam logic [15:0] OFF_CYCLE_HI = 16'h000C;

   logic [31:0]           mem [RAM_WORDS];
   logic [7:0]            fifo [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [63:0]           cnt;
   logic [31:0]           hi_shadow;
   logic                  ovf;

   logic                  is_mmio;
   logic                  is_write;
   logic [ADDR_WIDTH-1:0] idx;
   logic [15:0]           off;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  push_req;
   logic                  push;
   logic                  ovf_set;
   logic                  ovf_clr;
   logic                  lo_rd;
   logic [31:0]           mmio_rdata;

   // Address decode and FIFO flow control
   always_comb begin
      is_mmio  = (dmem_addr[31:16] == MMIO_BASE[31:16]);
      is_write = |dmem_we;
      idx      = dmem_addr[ADDR_WIDTH+1:2];
      off      = dmem_addr[15:0];
      empty    = (wr_ptr == rd_ptr);
      full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
      pop      = !empty && out_ready;
      push_req = dmem_en && is_mmio && (off == OFF_CONSOLE) && dmem_we[0];
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
      push     = push_req && (!full || pop);
      ovf_set  = push_req && full && !pop;
      ovf_clr  = dmem_en && is_mmio && (off == OFF_STATUS) && dmem_we[0] && dmem_d[2];
      lo_rd    = dmem_en && is_mmio && !is_write && (off == OFF_CYCLE_LO);
   end

   // MMIO read mux
   always_comb begin
      mmio_rdata = 32'h0;
      case (off)
         OFF_STATUS:   mmio_rdata = {29'h0, ovf, full, empty};
         OFF_CYCLE_LO: mmio_rdata = cnt[31:0];
         OFF_CYCLE_HI: mmio_rdata = hi_shadow;
         default:      mmio_rdata = 32'h0;
      endcase
   end

   assign out_valid = !empty;
   assign out_data  = fifo[rd_ptr[IW-1:0]];

   // Control state, counter and registered read data
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ovf       <= 1'b0;
         cnt       <= 64'h0;
         hi_shadow <= 32'h0;
         dmem_q    <= 32'h0;
      end else begin
         cnt <= cnt + 64'd1;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         if (lo_rd) hi_shadow <= cnt[63:32];
         if (dmem_en && !is_write) dmem_q <= is_mmio ? mmio_rdata : mem[idx];
      end
   end

   // Storage arrays carry no reset
   always_ff @(posedge clk) begin
      if (dmem_en && !is_mmio) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_we[i]) mem[idx][8*i +: 8] <= dmem_d[8*i +: 8];
         end
      end
      if (push) fifo[wr_ptr[IW-1:0]] <= dmem_d[7:0];
   end

endmodule
